// File: rtl/pcie_csr_pkg.sv
// rtl/pcie_csr_pkg.sv - shared offsets, response codes, FSM states and STAT layout for the PCIe CSR target
package pcie_csr_pkg;

    localparam logic [11:0] OFF_DFH     = 12'h000;
    localparam logic [11:0] OFF_SCRATCH = 12'h008;
    localparam logic [11:0] OFF_STAT    = 12'h010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_RSP = 2'd1,
        RD_RSP = 2'd2
    } state_t;

    // STAT register layout, MSB first
    typedef struct packed {
        logic [31:0] err_cnt;
        logic [17:0] rsvd_hi;
        logic [5:0]  ltssm;
        logic [6:0]  rsvd_lo;
        logic        link_up;
    } stat_t;

endpackage

// File: rtl/pcie_csr_responder.sv
// rtl/pcie_csr_responder.sv - 64-bit AXI4-Lite CSR target serving DFH, SCRATCHPAD and STAT
module pcie_csr_responder
    import pcie_csr_pkg::*;
#(
    parameter int                 ADDR_W    = 20,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 20'h10000,
    parameter logic [63:0]        DFH_VALUE = 64'h3000_0000_1000_0020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [63:0]       s_wdata,
    input  logic [7:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [63:0]       s_rdata,
    output logic [1:0]        s_rresp,
    input  logic              pcie_link_up,
    input  logic [5:0]        pcie_ltssm
);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] scratch;
    logic [31:0] err_cnt;
    logic [63:0] rdata_q;
    logic [1:0]  resp_q;

    logic        wr_go;
    logic        rd_go;
    logic        wr_bad;
    logic        rd_bad;
    stat_t       stat_v;
    logic [63:0] rd_value;

    // An access is bad if it falls outside the 4 KB window or is not 8-byte aligned
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[ADDR_W-1:12] != BASE_ADDR[ADDR_W-1:12]) || (a[2:0] != 3'b000);
    endfunction

    assign wr_go  = (state == IDLE) && s_awvalid && s_wvalid;
    assign rd_go  = (state == IDLE) && s_arvalid && !(s_awvalid && s_wvalid);
    assign wr_bad = addr_bad(s_awaddr);
    assign rd_bad = addr_bad(s_araddr);

    // Read data mux; link status is sampled live so it reflects the accept cycle
    always_comb begin
        stat_v         = '0;
        stat_v.link_up = pcie_link_up;
        stat_v.ltssm   = pcie_ltssm;
        stat_v.err_cnt = err_cnt;
        rd_value       = 64'h0;
        case (s_araddr[11:0])
            OFF_DFH:     rd_value = DFH_VALUE;
            OFF_SCRATCH: rd_value = scratch;
            OFF_STAT:    rd_value = stat_v;
            default:     rd_value = 64'h0;
        endcase
    end

    // State and register updates; all side effects happen on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            scratch <= 64'h0;
            err_cnt <= 32'h0;
            rdata_q <= 64'h0;
            resp_q  <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (wr_go) begin
                if (wr_bad) begin
                    resp_q <= RESP_SLVERR;
                    if (err_cnt != 32'hFFFF_FFFF) begin
                        err_cnt <= err_cnt + 32'd1;
                    end
                end else begin
                    resp_q <= RESP_OKAY;
                    if (s_awaddr[11:0] == OFF_SCRATCH) begin
                        for (int i = 0; i < 8; i++) begin
                            if (s_wstrb[i]) begin
                                scratch[i*8 +: 8] <= s_wdata[i*8 +: 8];
                            end
                        end
                    end
                end
            end else if (rd_go) begin
                if (rd_bad) begin
                    resp_q  <= RESP_SLVERR;
                    rdata_q <= 64'h0;
                    if (err_cnt != 32'hFFFF_FFFF) begin
                        err_cnt <= err_cnt + 32'd1;
                    end
                end else begin
                    resp_q  <= RESP_OKAY;
                    rdata_q <= rd_value;
                end
            end
        end
    end

    // Next state: accept from IDLE, return to IDLE on the response handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_go) begin
                    state_nxt = WR_RSP;
                end else if (rd_go) begin
                    state_nxt = RD_RSP;
                end
            end
            WR_RSP:  if (s_bready) state_nxt = IDLE;
            RD_RSP:  if (s_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; responses are gated by state so they are zero when idle
    always_comb begin
        s_awready = wr_go;
        s_wready  = wr_go;
        s_arready = rd_go;
        s_bvalid  = (state == WR_RSP);
        s_rvalid  = (state == RD_RSP);
        s_bresp   = (state == WR_RSP) ? resp_q : RESP_OKAY;
        s_rresp   = (state == RD_RSP) ? resp_q : RESP_OKAY;
        s_rdata   = rdata_q;
    end

endmodule

// File: tb/tb_pcie_csr_responder.sv
// tb/tb_pcie_csr_responder.sv - scoreboard bench for the PCIe CSR target
module tb_pcie_csr_responder;

    localparam logic [63:0] DFH = 64'h3000_0000_1000_0020;
    localparam logic [1:0]  OK  = 2'b00;
    localparam logic [1:0]  ERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [19:0] s_awaddr = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [63:0] s_wdata = '0;
    logic [7:0]  s_wstrb = '0;
    logic        s_bvalid;
    logic        s_bready = 1'b1;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [19:0] s_araddr = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        pcie_link_up = 1'b0;
    logic [5:0]  pcie_ltssm = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    pcie_csr_responder dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .pcie_link_up(pcie_link_up), .pcie_ltssm(pcie_ltssm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: pops the scoreboard whenever a response beat handshakes
    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_bvalid && s_bready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected: got bresp %h expected no beat", s_bresp);
            end else begin
                e = sb.pop_front();
                check("b_kind_is_write", 64'(e.is_wr), 64'd1);
                check("bresp", 64'(s_bresp), 64'(e.resp));
            end
        end
        if (!rst && s_rvalid && s_rready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL r_unexpected: got rdata %h expected no beat", s_rdata);
            end else begin
                e = sb.pop_front();
                check("r_kind_is_read", 64'(e.is_wr), 64'd0);
                check("rresp", 64'(s_rresp), 64'(e.resp));
                check("rdata", s_rdata, e.data);
            end
        end
    end

    task automatic wait_b_done();
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_bvalid && s_bready) begin got = 1; break; end
        end
        if (!got) timeout("b_handshake");
        @(posedge clk); #1;
    endtask

    task automatic wait_r_done();
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_rvalid && s_rready) begin got = 1; break; end
        end
        if (!got) timeout("r_handshake");
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [63:0] d, input logic [7:0] st,
                            input logic [1:0] resp);
        bit got = 0;
        sb.push_back('{is_wr: 1'b1, resp: resp, data: 64'h0});
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_awready && s_wready) begin got = 1; break; end
        end
        if (!got) timeout("aw_accept");
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("b_latency", 64'(s_bvalid), 64'd1);
        wait_b_done();
    endtask

    task automatic do_read(input logic [19:0] a, input logic [63:0] d, input logic [1:0] resp);
        bit got = 0;
        sb.push_back('{is_wr: 1'b0, resp: resp, data: d});
        s_araddr = a;
        s_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_arready) begin got = 1; break; end
        end
        if (!got) timeout("ar_accept");
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        check("r_latency", 64'(s_rvalid), 64'd1);
        wait_r_done();
    endtask

    initial begin
        bit got;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_awready), 64'd0);
        check("rst_arready", 64'(s_arready), 64'd0);
        check("rst_bvalid", 64'(s_bvalid), 64'd0);
        check("rst_rvalid", 64'(s_rvalid), 64'd0);
        check("rst_resp", 64'({s_bresp, s_rresp}), 64'd0);
        check("rst_rdata", s_rdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: DFH and initial scratch
        do_read(20'h10000, DFH, OK);
        do_read(20'h10008, 64'h0, OK);

        // 2: full and partial scratch writes
        do_write(20'h10008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, OK);
        do_read(20'h10008, 64'hDEAD_BEEF_CAFE_F00D, OK);
        do_write(20'h10008, 64'h0, 8'h0F, OK);
        do_read(20'h10008, 64'hDEAD_BEEF_0000_0000, OK);

        // 3: unmapped offset, read-only DFH
        do_read(20'h10FF8, 64'h0, OK);
        do_write(20'h10000, 64'h1234_5678_9ABC_DEF0, 8'hFF, OK);
        do_read(20'h10000, DFH, OK);

        // 4: errors and STAT
        do_read(20'h20000, 64'h0, ERR);
        do_write(20'h10004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ERR);
        do_read(20'h10008, 64'hDEAD_BEEF_0000_0000, OK);
        pcie_link_up = 1'b1; pcie_ltssm = 6'h11;
        do_read(20'h10010, 64'h0000_0002_0000_1101, OK);

        // 5: write wins a simultaneous read; B held back for 5 cycles
        sb.push_back('{is_wr: 1'b1, resp: OK, data: 64'h0});
        sb.push_back('{is_wr: 1'b0, resp: OK, data: 64'h1111_2222_3333_4444});
        s_bready = 1'b0;
        s_awaddr = 20'h10008; s_wdata = 64'h1111_2222_3333_4444; s_wstrb = 8'hFF;
        s_araddr = 20'h10008;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        check("race_awready", 64'(s_awready), 64'd1);
        check("race_arready_blocked", 64'(s_arready), 64'd0);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", 64'(s_bvalid), 64'd1);
            check("hold_bresp", 64'(s_bresp), 64'(OK));
            check("hold_arready", 64'(s_arready), 64'd0);
            @(posedge clk); #1;
        end
        s_bready = 1'b1;
        @(negedge clk);
        check("hs_cycle_arready", 64'(s_arready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_b_arready", 64'(s_arready), 64'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        check("race_r_latency", 64'(s_rvalid), 64'd1);
        wait_r_done();

        // 6: reset with a pending read response drops it
        s_rready = 1'b0;
        s_araddr = 20'h10010;
        s_arvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_arready) begin got = 1; break; end
        end
        if (!got) timeout("rst_ar_accept");
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        check("pending_rvalid", 64'(s_rvalid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_drops_rvalid", 64'(s_rvalid), 64'd0);
        rst = 1'b0;
        s_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_read(20'h10008, 64'h0, OK);
        do_read(20'h10010, 64'h0000_0000_0000_1101, OK);

        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) begin got = 1; break; end
            @(posedge clk);
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
